// File: rtl/cr16_decode_wb_pkg.sv
// Shared definitions for the CR16 decode/operand-fetch/writeback stage:
// opcode and extension codes, FSM states, decode classes and the decoder.
package cr16_pkg;

    localparam int FLAGS_W = 5;

    localparam logic [3:0] OP_REG   = 4'h0;
    localparam logic [3:0] OP_ANDI  = 4'h1;
    localparam logic [3:0] OP_ORI   = 4'h2;
    localparam logic [3:0] OP_XORI  = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_SUBI  = 4'h9;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_LUI   = 4'hF;

    localparam logic [3:0] EXT_AND  = 4'h1;
    localparam logic [3:0] EXT_OR   = 4'h2;
    localparam logic [3:0] EXT_XOR  = 4'h3;
    localparam logic [3:0] EXT_LSH  = 4'h4;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_ASHU = 4'h6;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;
    localparam logic [3:0] EXT_MOV  = 4'hD;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;

    // ARITH: write + PSR, CMP: PSR only, LOGIC: write only (includes shifts)
    typedef enum logic [1:0] {CLS_ARITH, CLS_CMP, CLS_LOGIC, CLS_ILLEGAL} cls_t;

    typedef enum logic [1:0] {B_RSRC, B_SIMM8, B_UIMM8, B_UIMM4} bsel_t;

    typedef struct packed {
        cls_t  cls;
        bsel_t bsel;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] inst);
        dec_t       d;
        logic [3:0] op;
        logic [3:0] ext;
        op     = inst[15:12];
        ext    = inst[7:4];
        d.cls  = CLS_ILLEGAL;
        d.bsel = B_RSRC;
        case (op)
            OP_REG: begin
                case (ext)
                    EXT_ADD, EXT_SUB:                   d.cls = CLS_ARITH;
                    EXT_CMP:                            d.cls = CLS_CMP;
                    EXT_AND, EXT_OR, EXT_XOR, EXT_MOV:  d.cls = CLS_LOGIC;
                    default:                            d.cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_SUBI: begin
                d.cls  = CLS_ARITH;
                d.bsel = B_SIMM8;
            end
            OP_CMPI: begin
                d.cls  = CLS_CMP;
                d.bsel = B_SIMM8;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_MOVI, OP_LUI: begin
                d.cls  = CLS_LOGIC;
                d.bsel = B_UIMM8;
            end
            OP_SHIFT: begin
                if (ext == EXT_LSH || ext == EXT_ASHU) begin
                    d.cls = CLS_LOGIC;
                end else if (ext[3:1] == 3'b000) begin
                    d.cls  = CLS_LOGIC;
                    d.bsel = B_UIMM4;
                end
            end
            default: d.cls = CLS_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cr16_decode_wb_if.sv
// Instruction handshake, ALU operand/result and writeback bus of the CR16 stage.
// The illegal pulse exists only when CR16_ILLEGAL_TRAP_EN is defined.
interface cr16_decode_wb_if #(
    parameter int DATA_W = 16
);
    logic                        inst_valid;
    logic                        inst_ready;
    logic [15:0]                 inst;
    logic [DATA_W-1:0]           alu_a;
    logic [DATA_W-1:0]           alu_b;
    logic [7:0]                  alu_opcode;
    logic [DATA_W-1:0]           alu_c;
    logic [cr16_pkg::FLAGS_W-1:0] alu_flags;
    logic [cr16_pkg::FLAGS_W-1:0] psr;
    logic                        wb_valid;
    logic                        wb_we;
    logic [3:0]                  wb_reg;
    logic [DATA_W-1:0]           wb_data;
`ifdef CR16_ILLEGAL_TRAP_EN
    logic                        illegal;
`endif

    modport slave (
        input  inst_valid, inst, alu_c, alu_flags,
        output inst_ready, alu_a, alu_b, alu_opcode, psr,
        output wb_valid, wb_we, wb_reg, wb_data
`ifdef CR16_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport master (
        output inst_valid, inst, alu_c, alu_flags,
        input  inst_ready, alu_a, alu_b, alu_opcode, psr,
        input  wb_valid, wb_we, wb_reg, wb_data
`ifdef CR16_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );

endinterface

// File: rtl/cr16_decode_wb_regfile.sv
// 16x16 register file: two combinational read ports, one synchronous write
// port, asynchronous active-low clear.
module cr16_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] ra_idx,
    output logic [DATA_W-1:0]        ra_data,
    input  logic [$clog2(NREGS)-1:0] rb_idx,
    output logic [DATA_W-1:0]        rb_data,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic [DATA_W-1:0]        wd
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = regs[ra_idx];
    assign rb_data = regs[rb_idx];

endmodule

// File: rtl/cr16_decode_wb.sv
// CR16 decode / operand-fetch / writeback stage around an external combinational ALU.
// Optional feature: define CR16_ILLEGAL_TRAP_EN to trap undecodable instructions.
module cr16_decode_wb
    import cr16_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input logic             clk,
    input logic             rst_n,
    cr16_decode_wb_if.slave bus
);

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    dec_t                 dec;
    logic [3:0]           rdest;
    logic [3:0]           rsrc;
    logic [DATA_W-1:0]    ra_data;
    logic [DATA_W-1:0]    rb_data;
    logic [DATA_W-1:0]    opa;
    logic [DATA_W-1:0]    opr;
    logic [DATA_W-1:0]    opb;
    logic                 wr_en;
    logic                 psr_ld;

    logic [DATA_W-1:0]    alu_a_p1;
    logic [DATA_W-1:0]    alu_b_p1;
    logic [7:0]           opcode_p1;
    logic [3:0]           rdest_p1;
    cls_t                 cls_p1;
    logic [DATA_W-1:0]    wb_data_p2;
    logic [FLAGS_W-1:0]   flags_p2;
    logic [FLAGS_W-1:0]   psr_q;

    assign rdest  = bus.inst[11:8];
    assign rsrc   = bus.inst[3:0];
    assign dec    = decode(bus.inst);
    assign accept = bus.inst_valid && bus.inst_ready;

    assign bus.inst_ready = (state == ST_IDLE) || (state == ST_WB);
    assign bus.wb_valid   = (state == ST_WB);
    assign psr_ld         = (state == ST_WB) && (cls_p1 == CLS_ARITH || cls_p1 == CLS_CMP);

`ifdef CR16_ILLEGAL_TRAP_EN
    assign wr_en       = (state == ST_WB) && (cls_p1 == CLS_ARITH || cls_p1 == CLS_LOGIC);
    assign bus.illegal = (state == ST_WB) && (cls_p1 == CLS_ILLEGAL);
`else
    assign wr_en       = (state == ST_WB) && (cls_p1 != CLS_CMP);
`endif

    cr16_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_idx  (rdest),
        .ra_data (ra_data),
        .rb_idx  (rsrc),
        .rb_data (rb_data),
        .we      (wr_en),
        .wa      (rdest_p1),
        .wd      (wb_data_p2)
    );

    // An accept in WB coincides with the pending write, so forward it
    assign opa = (wr_en && rdest_p1 == rdest) ? wb_data_p2 : ra_data;
    assign opr = (wr_en && rdest_p1 == rsrc)  ? wb_data_p2 : rb_data;

    always_comb begin
        opb = opr;
        case (dec.bsel)
            B_SIMM8: opb = {{(DATA_W-8){bus.inst[7]}}, bus.inst[7:0]};
            B_UIMM8: opb = {{(DATA_W-8){1'b0}}, bus.inst[7:0]};
            B_UIMM4: opb = {{(DATA_W-4){1'b0}}, bus.inst[3:0]};
            default: opb = opr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = accept ? ST_EXEC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_p1   <= '0;
            alu_b_p1   <= '0;
            opcode_p1  <= '0;
            rdest_p1   <= '0;
            cls_p1     <= CLS_ARITH;
            wb_data_p2 <= '0;
            flags_p2   <= '0;
            psr_q      <= '0;
        end else begin
            // p1: operands latched at accept, held until the next accept
            if (accept) begin
                alu_a_p1  <= opa;
                alu_b_p1  <= opb;
                opcode_p1 <= {bus.inst[15:12], bus.inst[7:4]};
                rdest_p1  <= rdest;
                cls_p1    <= dec.cls;
            end
            // p2: ALU result captured at the close of EXEC
            if (state == ST_EXEC) begin
                wb_data_p2 <= bus.alu_c;
                flags_p2   <= bus.alu_flags;
            end
            if (psr_ld) begin
                psr_q <= flags_p2;
            end
        end
    end

    assign bus.alu_a      = alu_a_p1;
    assign bus.alu_b      = alu_b_p1;
    assign bus.alu_opcode = opcode_p1;
    assign bus.psr        = psr_q;
    assign bus.wb_we      = wr_en;
    assign bus.wb_reg     = rdest_p1;
    assign bus.wb_data    = wb_data_p2;

endmodule
